led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Parametrised multi-LED pattern generator for the DE-board LED bank, clocked from CLOCK_50.
- Drives N_LEDS outputs in one of three modes: BLINK, CHASE or BOUNCE.
- Two debounced pushbuttons control it: one selects speed, one advances the mode.
- Exposes the current mode and a step pulse for the board top level or other blocks.

Parameters:
- N_LEDS, 8, number of LED outputs (>=1).
- CNT_W, 27, tick counter width; must hold max(SLOW_DIV, FAST_DIV) - 1.
- SLOW_DIV, 25_000_000, clock cycles per pattern step in slow speed.
- FAST_DIV, 2_500_000, clock cycles per pattern step in fast speed.
- DEB_CYCLES, 1_000_000, consecutive stable samples before a key change is accepted (>=1).

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- KEY  in  2  active-low pushbuttons, asynchronous to the clock. KEY[0] is speed (low = fast); KEY[1] is mode advance.
- LEDG  out  N_LEDS  LED drive, 1 = lit; registered.
- MODE  out  2  current mode: 0 BLINK, 1 CHASE, 2 BOUNCE (3 never driven); registered.
- TICK  out  1  one-cycle pulse, high in the cycle a new pattern step appears on LEDG.

Behaviour:
Clock and reset:
- One clock, CLOCK_50; reset is asynchronous and active-low (RST_N).

Reset values:
- LEDG=0, MODE=BLINK, TICK=0, tick counter=0.
- BOUNCE direction=left.
- Both debounced key levels=1 (released); debounce counters=0; synchronisers=1.

Key path (per key):
- 2-flop synchroniser, then debounce counter.
- Counter clears whenever the synced sample differs from the debounced level.
- When the counter reaches DEB_CYCLES-1 with the sample still differing, the debounced level takes the sample and the counter clears.
- Mode press = debounced KEY[1] 1->0 transition.
- Holding the key does not repeat; release produces nothing.
- Latency: KEY[1] held low from before rising edge e -> MODE updates on edge e+DEB_CYCLES+2.

Speed:
- DIV = FAST_DIV when debounced KEY[0]=0, else SLOW_DIV.

Tick counter:
- Increments each cycle.
- On the edge where counter >= DIV-1: counter returns to 0 and a step occurs.
- The >= (not ==) compare is mandatory: a fast->slow or slow->fast change mid-period never overruns. If the counter is already past the new DIV-1, the step fires on the next edge.
- With a constant DIV, steps occur every DIV cycles; the first step is on the DIV-th edge after reset release.

Step action by mode:
- BLINK: LEDG <= ~LEDG (all LEDs identical).
- CHASE: rotate left by one; LEDG[N_LEDS-1] wraps to LEDG[0].
- BOUNCE: shift one-hot in the current direction. At LEDG[N_LEDS-1] the direction becomes right; at LEDG[0] it becomes left. The end LED is shown for exactly one step, with no double dwell.
- N_LEDS=1: CHASE and BOUNCE hold LEDG=1.

Mode advance (on press):
- MODE goes BLINK->CHASE->BOUNCE->BLINK.
- On the same edge: tick counter <= 0; TICK=0.
- LEDG <= initial value of the new mode: BLINK all 0; CHASE and BOUNCE = 1 (LSB lit), direction left.
- A press and a step on the same edge: the press wins and the step is discarded.

TICK:
- Registered; high for exactly the one cycle following each step edge.

Reset mid-operation:
- Returns immediately to reset values, including mid-debounce (partial count discarded) and mid-BOUNCE.

Decomposition:
- Package led_pkg:
  - mode_t enum (MODE_BLINK=0, MODE_CHASE=1, MODE_BOUNCE=2).
  - function next_mode.
  - local constant MODE_W=2.
- Sub-module key_debounce (params DEB_CYCLES; ports CLOCK_50, RST_N, key_in, level, fall_pulse), instantiated twice.
- Tick counter and pattern FSM stay in led_pattern_gen.

Test Plan:
All scenarios use N_LEDS=4, SLOW_DIV=10, FAST_DIV=4, DEB_CYCLES=3.
1. Reset, keys released, run 40 cycles -> MODE=0, LEDG toggles 0000->1111->0000 every 10 cycles, first change on edge 10; TICK pulses 4 times.
2. KEY[1] low 10 cycles, then high -> MODE=1 on edge e+5, LEDG=0001. Steps then give 0010, 0100, 1000, 0001; no further mode change while held.
3. Two more presses -> MODE=2 then MODE=0. In BOUNCE, run 8 steps -> 0001,0010,0100,1000,0100,0010,0001,0010.
4. KEY[0] low while slow counter=7 -> after debounce, counter>=3 forces a step on the next edge; steps then every 4 cycles. Glitch of KEY[0] low for 2 cycles -> no speed change.
5. Press timed so the mode edge coincides with a step edge -> new mode's initial LEDG, TICK=0, no step applied.
6. Assert RST_N mid-BOUNCE and mid-debounce of KEY[1] -> outputs reset asynchronously before the next clock edge. After release, KEY[1] still low needs a full DEB_CYCLES before a press registers.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: shared mode encoding and mode sequencing for the LED pattern generator.
// Revision 1.0
`default_nettype none

package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BLINK  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2
  } mode_t;

  function automatic mode_t next_mode(input mode_t cur);
    case (cur)
      MODE_BLINK: return MODE_CHASE;
      MODE_CHASE: return MODE_BOUNCE;
      default:    return MODE_BLINK;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus stable-count debouncer for an active-low key.
// Revision 1.0
`default_nettype none

module key_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic CLOCK_50,
  input  logic RST_N,
  input  logic key_in,
  output logic level,
  output logic fall_pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      cnt        <= '0;
      level      <= 1'b1;
      fall_pulse <= 1'b0;
    end else begin
      sync1      <= key_in;
      sync2      <= sync1;
      fall_pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt >= LAST) begin
        // Accepting a new low level is the one-shot press event.
        level      <= sync2;
        cnt        <= '0;
        fall_pulse <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: BLINK / CHASE / BOUNCE LED pattern generator with debounced speed and mode keys.
// Revision 1.0
`default_nettype none

module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LEDS     = 8,
  parameter int CNT_W      = 27,
  parameter int SLOW_DIV   = 25_000_000,
  parameter int FAST_DIV   = 2_500_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic              CLOCK_50,
  input  logic              RST_N,
  input  logic [1:0]        KEY,
  output logic [N_LEDS-1:0] LEDG,
  output logic [MODE_W-1:0] MODE,
  output logic              TICK
);

  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

  logic              speed_level;
  logic              unused_speed_fall;
  logic              unused_mode_level;
  logic              mode_press;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  div_last;
  logic              step;
  logic              dir_left;
  mode_t             mode;
  mode_t             mode_nxt;
  logic [N_LEDS-1:0] rot_left;
  logic [N_LEDS-1:0] bounce_nxt;
  logic              bounce_dir_nxt;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_speed (
    .CLOCK_50   (CLOCK_50),
    .RST_N      (RST_N),
    .key_in     (KEY[0]),
    .level      (speed_level),
    .fall_pulse (unused_speed_fall)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_mode (
    .CLOCK_50   (CLOCK_50),
    .RST_N      (RST_N),
    .key_in     (KEY[1]),
    .level      (unused_mode_level),
    .fall_pulse (mode_press)
  );

  assign div_last = speed_level ? SLOW_LAST : FAST_LAST;
  // >= so a speed change that leaves the counter past the new period steps at once.
  assign step     = (cnt >= div_last);
  assign mode_nxt = next_mode(mode);
  assign rot_left = (LEDG << 1) | (LEDG >> (N_LEDS - 1));
  assign MODE     = mode;

  always_comb begin
    bounce_nxt     = LEDG;
    bounce_dir_nxt = dir_left;
    if (N_LEDS == 1) begin
      bounce_nxt = N_LEDS'(1);
    end else if (dir_left && LEDG[N_LEDS-1]) begin
      bounce_nxt     = LEDG >> 1;
      bounce_dir_nxt = 1'b0;
    end else if (dir_left) begin
      bounce_nxt = LEDG << 1;
    end else if (LEDG[0]) begin
      bounce_nxt     = LEDG << 1;
      bounce_dir_nxt = 1'b1;
    end else begin
      bounce_nxt = LEDG >> 1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      cnt      <= '0;
      LEDG     <= '0;
      mode     <= MODE_BLINK;
      TICK     <= 1'b0;
      dir_left <= 1'b1;
    end else begin
      TICK <= 1'b0;
      if (mode_press) begin
        // A press on a step edge discards that step.
        mode     <= mode_nxt;
        cnt      <= '0;
        dir_left <= 1'b1;
        LEDG     <= (mode_nxt == MODE_BLINK) ? '0 : N_LEDS'(1);
      end else if (step) begin
        cnt  <= '0;
        TICK <= 1'b1;
        case (mode)
          MODE_BLINK:  LEDG <= ~LEDG;
          MODE_CHASE:  LEDG <= rot_left;
          MODE_BOUNCE: begin
            LEDG     <= bounce_nxt;
            dir_left <= bounce_dir_nxt;
          end
          default: ;
        endcase
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed stimulus with an edge-tagged scoreboard of expected pattern steps.
// Revision 1.0
`default_nettype none

module tb_led_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic [1:0] key;
  logic [3:0] ledg;
  logic [1:0] mode;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic [3:0] led;
  } exp_t;

  exp_t sb[$];
  exp_t popped;

  led_pattern_gen #(
    .N_LEDS(4), .CNT_W(8), .SLOW_DIV(10), .FAST_DIV(4), .DEB_CYCLES(3)
  ) dut (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .KEY      (key),
    .LEDG     (ledg),
    .MODE     (mode),
    .TICK     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; at a negedge it equals the index of the last rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int at, input logic [1:0] m, input logic [3:0] l);
    exp_t e;
    e.cyc  = at;
    e.mode = m;
    e.led  = l;
    sb.push_back(e);
  endtask

  task automatic go_to(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic drained(input string tag);
    #1;
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && tick) begin
      chk("tick_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        popped = sb.pop_front();
        chk("tick_cycle", 32'(cyc), 32'(popped.cyc));
        chk("tick_mode", 32'(mode), 32'(popped.mode));
        chk("tick_ledg", 32'(ledg), 32'(popped.led));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    key   = 2'b11;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ledg", 32'(ledg), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    rst_n = 1'b1;

    // Slow BLINK from reset.
    push(10, 2'd0, 4'hF); push(20, 2'd0, 4'h0);
    push(30, 2'd0, 4'hF); push(40, 2'd0, 4'h0);
    go_to(40); drained("t1_drain");

    // Press into CHASE, held 10 cycles.
    key[1] = 1'b0;
    go_to(45); chk("t2_mode_before", 32'(mode), 32'd0);
    go_to(46); chk("t2_mode", 32'(mode), 32'd1);
    chk("t2_ledg", 32'(ledg), 32'h1);
    chk("t2_tick", 32'(tick), 32'd0);
    push(56, 2'd1, 4'h2); push(66, 2'd1, 4'h4);
    push(76, 2'd1, 4'h8); push(86, 2'd1, 4'h1);
    go_to(50); key[1] = 1'b1;
    go_to(86); drained("t2_drain");
    chk("t2_no_repeat", 32'(mode), 32'd1);

    // BOUNCE for 8 steps, then back to BLINK.
    go_to(87); key[1] = 1'b0;
    go_to(92); chk("t3_mode_before", 32'(mode), 32'd1);
    go_to(93); chk("t3_mode_bounce", 32'(mode), 32'd2);
    chk("t3_ledg_init", 32'(ledg), 32'h1);
    key[1] = 1'b1;
    push(103, 2'd2, 4'h2); push(113, 2'd2, 4'h4); push(123, 2'd2, 4'h8); push(133, 2'd2, 4'h4);
    push(143, 2'd2, 4'h2); push(153, 2'd2, 4'h1); push(163, 2'd2, 4'h2); push(173, 2'd2, 4'h4);
    go_to(174); drained("t3_drain");
    key[1] = 1'b0;
    go_to(180); chk("t3_mode_blink", 32'(mode), 32'd0);
    chk("t3_ledg_blink", 32'(ledg), 32'h0);
    key[1] = 1'b1;

    // Slow->fast with the counter already past the fast period, then back, then a glitch.
    go_to(182); key[0] = 1'b0;
    push(188, 2'd0, 4'hF); push(192, 2'd0, 4'h0);
    push(196, 2'd0, 4'hF); push(200, 2'd0, 4'h0);
    go_to(200); drained("t4_fast_drain");
    key[0] = 1'b1;
    push(204, 2'd0, 4'hF); push(214, 2'd0, 4'h0); push(224, 2'd0, 4'hF);
    go_to(215); key[0] = 1'b0;
    go_to(217); key[0] = 1'b1;
    push(234, 2'd0, 4'h0);
    go_to(234); drained("t4_glitch_drain");

    // Press landing on a step edge.
    go_to(238); key[1] = 1'b0;
    go_to(243); chk("t5_ledg_before", 32'(ledg), 32'h0);
    go_to(244); chk("t5_mode", 32'(mode), 32'd1);
    chk("t5_ledg", 32'(ledg), 32'h1);
    chk("t5_tick", 32'(tick), 32'd0);
    key[1] = 1'b1;
    push(254, 2'd1, 4'h2);

    // Into BOUNCE, then reset mid-pattern and mid-debounce.
    go_to(249); key[1] = 1'b0;
    go_to(255); chk("t6_mode_bounce", 32'(mode), 32'd2);
    key[1] = 1'b1;
    push(265, 2'd2, 4'h2); push(275, 2'd2, 4'h4);
    go_to(276); drained("t6_drain");
    key[1] = 1'b0;
    go_to(279); chk("t6_ledg_pre", 32'(ledg), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ledg", 32'(ledg), 32'd0);
    chk("t6_rst_mode", 32'(mode), 32'd0);
    chk("t6_rst_tick", 32'(tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    go_to(5); chk("t6_mode_partial", 32'(mode), 32'd0);
    go_to(6); chk("t6_mode_full", 32'(mode), 32'd1);
    chk("t6_ledg_chase", 32'(ledg), 32'h1);
    key[1] = 1'b1;
    push(16, 2'd1, 4'h2);
    go_to(16); drained("t6_final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
